// File: rtl/orb_window_7x7_reader.sv
// -----------------------------------------------------------------------------
// orb_window_7x7_reader
//
// Consumer-side reader for the 7-line pixel buffer chain of the ORB front end.
// On every accepted pixel the current pixel and the six delayed-row taps are
// shifted into a 7x7 register window. The block tracks the raster position of
// the incoming stream. It flags windows that are complete and lie wholly
// inside the frame, and it reports the position of the window centre.
//
// Parameters
//   WIDTH       pixels per line (must match the line-buffer depth)
//   HEIGHT      lines per frame
//   PW          pixel width in bits
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   en          pixel strobe, shared with the line buffers
//   sof         start of frame, qualified by en, marks pixel (0,0)
//   row0        newest pixel (current line)
//   row1..row6  line-buffer taps, rowK is K lines older than row0
//   win         7x7 window, pixel (r,c) at [(r*7+c)*PW +: PW], r=0 oldest line
//   win_valid   window complete and in-frame (one cycle after the accept)
//   cx, cy      column / row of the window centre win(3,3)
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module orb_window_7x7_reader #(
  parameter int WIDTH  = 684,
  parameter int HEIGHT = 480,
  parameter int PW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sof,
  input  logic [PW-1:0]     row0,
  input  logic [PW-1:0]     row1,
  input  logic [PW-1:0]     row2,
  input  logic [PW-1:0]     row3,
  input  logic [PW-1:0]     row4,
  input  logic [PW-1:0]     row5,
  input  logic [PW-1:0]     row6,
  output logic [49*PW-1:0]  win,
  output logic              win_valid,
  output logic [10:0]       cx,
  output logic [9:0]        cy,
  output logic              frame_done
);

  localparam logic [10:0] LastCol = 11'(WIDTH - 1);
  localparam logic [9:0]  LastRow = 10'(HEIGHT - 1);

  logic [10:0]      col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [49*PW-1:0] win_q, win_d;
  logic             valid_q, valid_d;
  logic [10:0]      cx_q, cx_d;
  logic [9:0]       cy_q, cy_d;
  logic             done_q, done_d;

  logic [10:0]      pc;
  logic [9:0]       pr;
  logic [7*PW-1:0]  colIn;

  // The new right-hand column, ordered so that slice r feeds window row r.
  // Row 0 of the window is the oldest line, so it takes row6.
  assign colIn = {row0, row1, row2, row3, row4, row5, row6};

  // Next-state logic. An accept shifts the window left by one column and
  // advances the raster counters from the accepted pixel position. A sof
  // accept forces that position to (0,0), which also resynchronises a
  // frame that was aborted part-way. Idle cycles hold everything except the
  // two single-cycle flags.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pc      = sof ? 11'd0 : col_q;
    pr      = sof ? 10'd0 : row_q;

    if (en) begin
      for (int r = 0; r < 7; r++) begin
        for (int c = 0; c < 6; c++) begin
          win_d[(r*7+c)*PW +: PW] = win_q[(r*7+c+1)*PW +: PW];
        end
        win_d[(r*7+6)*PW +: PW] = colIn[r*PW +: PW];
      end

      valid_d = (pc >= 11'd6) && (pr >= 10'd6);
      cx_d    = pc - 11'd3;
      cy_d    = pr - 10'd3;
      done_d  = (pc == LastCol) && (pr == LastRow);

      // The row is always reloaded from pr so that a mid-line sof also
      // clears the row counter.
      if (pc < LastCol) begin
        col_d = pc + 11'd1;
        row_d = pr;
      end else begin
        col_d = 11'd0;
        row_d = (pr == LastRow) ? 10'd0 : pr + 10'd1;
      end
    end
  end

  // State register. Reset takes priority over a simultaneous accept, so the
  // pixel presented in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
    end
  end

  assign win        = win_q;
  assign win_valid  = valid_q;
  assign cx         = cx_q;
  assign cy         = cy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_orb_window_7x7_reader.sv
// -----------------------------------------------------------------------------
// tb_orb_window_7x7_reader
//
// Scoreboard bench for orb_window_7x7_reader with a 16x10 frame. The driver
// feeds one cycle per negative edge and pushes the expected registered
// response. The monitor pops one entry shortly after each rising edge and
// compares it with the DUT outputs. Tap data follow value = col + 16*line,
// with rowK carrying the value for line-K. A valid window at accepted
// position (pc,pr) therefore holds (pc-6+c) + 16*(pr-6+r) at (r,c).
// -----------------------------------------------------------------------------
module tb_orb_window_7x7_reader;

  localparam int W  = 16;
  localparam int H  = 10;
  localparam int PW = 8;

  typedef struct {
    logic        valid;
    logic        fd;
    logic        chkPos;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        chkWin;
    logic [391:0] win;
    int          phase;
  } exp_t;

  logic clk;
  logic rst;
  logic en;
  logic sof;
  logic [PW-1:0] row0, row1, row2, row3, row4, row5, row6;
  logic [49*PW-1:0] win;
  logic win_valid;
  logic [10:0] cx;
  logic [9:0] cy;
  logic frame_done;

  exp_t sb[$];
  int numChecks = 0;
  int numFails = 0;
  int validCnt[6];
  int fdCnt[6];
  int phase = 0;

  int bc = 0;
  int br = 0;
  logic [10:0] lastCx = '0;
  logic [9:0] lastCy = '0;
  logic [391:0] lastWin = '0;
  logic lastWinKnown = 1'b1;

  orb_window_7x7_reader #(.WIDTH(W), .HEIGHT(H), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .sof(sof),
    .row0(row0), .row1(row1), .row2(row2), .row3(row3),
    .row4(row4), .row5(row5), .row6(row6),
    .win(win), .win_valid(win_valid), .cx(cx), .cy(cy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int c, input int r, input int k);
    int v;
    v = c + 16 * (r - k);
    return v[7:0];
  endfunction

  function automatic logic [391:0] expWindow(input int pc, input int pr);
    logic [391:0] w;
    w = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        w[(r*7+c)*8 +: 8] = pix(pc - 6 + c, pr - 6 + r, 0);
    return w;
  endfunction

  // One stimulus cycle: reset, accept or idle, with its expected response.
  task automatic applyStimulus(input logic enIn, input logic sofIn, input logic rstIn);
    exp_t e;
    int pc, pr;
    @(negedge clk);
    rst = rstIn;
    en  = enIn;
    sof = sofIn;
    e.phase = phase;
    if (rstIn || !enIn) begin
      {row0, row1, row2, row3} = $urandom;
      {row4, row5, row6} = 24'($urandom);
    end
    if (rstIn) begin
      e.valid = 1'b0; e.fd = 1'b0; e.chkPos = 1'b1; e.cx = '0; e.cy = '0;
      e.chkWin = 1'b1; e.win = '0;
      bc = 0; br = 0;
      lastCx = '0; lastCy = '0; lastWin = '0; lastWinKnown = 1'b1;
    end else if (enIn) begin
      if (sofIn) begin
        bc = 0; br = 0;
      end
      pc = bc; pr = br;
      row0 = pix(pc, pr, 0); row1 = pix(pc, pr, 1); row2 = pix(pc, pr, 2);
      row3 = pix(pc, pr, 3); row4 = pix(pc, pr, 4); row5 = pix(pc, pr, 5);
      row6 = pix(pc, pr, 6);
      e.valid  = (pc >= 6) && (pr >= 6);
      e.fd     = (pc == W - 1) && (pr == H - 1);
      e.chkPos = 1'b1;
      e.cx     = 11'(pc - 3);
      e.cy     = 10'(pr - 3);
      e.chkWin = e.valid;
      e.win    = expWindow(pc, pr);
      lastCx = e.cx; lastCy = e.cy; lastWin = e.win; lastWinKnown = e.valid;
      if (pc < W - 1) bc = pc + 1;
      else begin
        bc = 0;
        br = (pr == H - 1) ? 0 : pr + 1;
      end
    end else begin
      e.valid = 1'b0; e.fd = 1'b0; e.chkPos = 1'b1; e.cx = lastCx; e.cy = lastCy;
      e.chkWin = lastWinKnown; e.win = lastWin;
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    numChecks++;
    if (win_valid !== e.valid) begin
      numFails++;
      $display("[TB] FAIL win_valid (phase %0d): got %0b expected %0b", e.phase, win_valid, e.valid);
    end
    numChecks++;
    if (frame_done !== e.fd) begin
      numFails++;
      $display("[TB] FAIL frame_done (phase %0d): got %0b expected %0b", e.phase, frame_done, e.fd);
    end
    if (e.chkPos) begin
      numChecks++;
      if (cx !== e.cx || cy !== e.cy) begin
        numFails++;
        $display("[TB] FAIL centre (phase %0d): got cx=%0d cy=%0d expected cx=%0d cy=%0d",
                 e.phase, cx, cy, e.cx, e.cy);
      end
    end
    if (e.chkWin) begin
      numChecks++;
      if (win !== e.win) begin
        numFails++;
        $display("[TB] FAIL window (phase %0d): got %h expected %h", e.phase, win, e.win);
      end
    end
    if (win_valid === 1'b1) validCnt[e.phase]++;
    if (frame_done === 1'b1) fdCnt[e.phase]++;
  endtask

  // Monitor: one expected entry per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic checkCount(input string name, input int act, input int expv);
    numChecks++;
    if (act != expv) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sof = 1'b0;
    {row0, row1, row2, row3, row4, row5, row6} = '0;
    foreach (validCnt[i]) begin validCnt[i] = 0; fdCnt[i] = 0; end

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] phase 1: continuous frame");
    phase = 1;
    for (int i = 0; i < W * H; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] phase 2: en toggling across a frame");
    phase = 2;
    for (int i = 0; i < W * H; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] phase 3: sof at pixel (8,4)");
    phase = 3;
    for (int i = 0; i < 4 * W + 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 30) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7 * W + 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] phase 4: reset with en at pixel (10,7)");
    phase = 4;
    applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] phase 5: sof on the natural last pixel");
    phase = 5;
    for (int i = 0; i < W * H - 1; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6 * W + 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checkCount("scoreboard drained", sb.size(), 0);
    checkCount("valid windows frame 1", validCnt[1], 40);
    checkCount("frame_done frame 1", fdCnt[1], 1);
    checkCount("valid windows toggled frame", validCnt[2], 40);
    checkCount("frame_done toggled frame", fdCnt[2], 1);
    checkCount("valid windows after sof", validCnt[3], 14);
    checkCount("frame_done aborted frame", fdCnt[3], 0);
    checkCount("frame_done sof on last pixel", fdCnt[5], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/orb_window_7x7_reader.md
# orb_window_7x7_reader

Consumer-side reader for the 7-line pixel buffer chain in the ORB front end. Each accepted pixel cycle, it takes the current pixel plus six delayed-row taps and shifts them into a 7x7 register window. It tracks raster position and flags when a complete, in-frame 7x7 neighbourhood is available for the FAST/BRIEF stages. It sits directly downstream of the line buffers and drives the corner-detection pipeline.

## Interface
- WIDTH, 684, pixels per line; must match the line-buffer depth.
- HEIGHT, 480, lines per frame.
- PW, 8, pixel width in bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel strobe; same strobe that advances the line buffers.
- sof  in  1  start of frame; qualified by en; marks the pixel at (0,0).
- row0  in  PW  current pixel (newest line).
- row1..row6  in  PW each  line-buffer taps; rowK is K lines older than row0.
- win  out  49*PW  window; pixel (r,c) at bits [(r*7+c)*PW +: PW]. r=0 is the top (oldest) line and equals row6. c=0 is the left (oldest) column.
- win_valid  out  1  window is complete and lies entirely inside the frame.
- cx  out  11  column of the window centre, win(3,3).
- cy  out  10  row of the window centre.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Position counters col (0..WIDTH-1) and row (0..HEIGHT-1) hold the raster position of the next pixel to be accepted.
- Accept cycle (en=1):
  - Every window row shifts left by one: win(r,c) <= win(r,c+1) for c=0..5, and win(r,6) <= row(6-r).
  - Let (pc,pr) be the position of the accepted pixel. If sof=1 then (pc,pr)=(0,0); otherwise (pc,pr)=(col,row).
  - win_valid <= (pc>=6) && (pr>=6); cx <= pc-3; cy <= pr-3.
  - Counter advance from (pc,pr): if pc<WIDTH-1, col <= pc+1. Otherwise col <= 0 and row <= pr+1, wrapping to 0 when pr=HEIGHT-1.
  - frame_done <= (pc==WIDTH-1) && (pr==HEIGHT-1).
- Idle cycle (en=0): window, col, row, cx and cy hold; win_valid <= 0; frame_done <= 0.
- Line wrap: the window is not flushed. The first six windows of each line contain columns from the previous line. win_valid=0 for those windows masks them (pc<6).
- sof behaviour:
  - sof resynchronises the counters mid-frame. No frame_done is emitted for an aborted frame.
  - If sof coincides with the natural last pixel, sof wins: position is (0,0) and frame_done=0.
  - sof without en is ignored.
- Arithmetic: cx/cy are unsigned and are meaningful only while win_valid=1. Counter compares use full width with no overflow, since WIDTH ≤ 2047 and HEIGHT ≤ 1023.

## Timing
- All outputs are registered. win, win_valid, cx, cy and frame_done reflect the pixel accepted on the previous clock edge (latency 1).
- win_valid is never high for two windows without an intervening accept; it tracks en exactly one cycle later.
- Reset (rst=1 at an edge): col=0, row=0, all win bits 0, win_valid=0, cx=0, cy=0, frame_done=0. Reset mid-frame discards the partial frame with no frame_done. The first accept after reset is treated as (0,0) whether or not sof is asserted.
- If rst and en are high in the same cycle, rst wins and the pixel is dropped.
- The block has no back-pressure and assumes the downstream stage takes one window per accept.

## Test plan
- Params WIDTH=16, HEIGHT=10, en=1 continuous, pixel value = col+16*row in every tap with row-offset consistency:
  - win_valid rises first one cycle after pixel (6,6) is accepted, with cx=3, cy=3, and win(3,3)=0x33.
  - win_valid stays high for 10 windows per line on lines 6..9, giving 40 valid windows per frame.
- Continuing the same stream: frame_done pulses exactly once, one cycle after pixel (15,9). The next pixel is then (0,0) and win_valid=0.
- en toggling 1-0-1 across a whole frame:
  - Window contents, cx and cy are identical to the continuous run at each accept.
  - win_valid is 0 on every cycle following en=0.
- sof asserted at pixel (8,4) mid-frame:
  - That pixel is treated as (0,0) and no frame_done is emitted for the aborted frame.
  - The first valid window again arrives at cx=3, cy=3.
- rst pulsed for one cycle at pixel (10,7) while win_valid=1:
  - Next cycle, all outputs are 0 and win is all zero.
  - Counting restarts at (0,0).
- sof and en high on the natural last pixel (15,9):
  - frame_done stays 0.
  - Following pixels count from (1,0).
